// File: rtl/elbeth_pipeline_controller.sv
// Pipeline hazard/trap controller: prioritises traps, eret, branches, memory
// stalls and load-use interlocks into per-stage stall/flush and PC steering.
module elbeth_pipeline_controller #(
    parameter int STAGES       = 3,
    parameter int MEM_TIMEOUT  = 255,
    parameter int ERET_BUBBLES = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              imem_en,
    input  logic              imem_ready,
    input  logic              dmem_en,
    input  logic              dmem_ready,
    input  logic              branch_taken,
    input  logic              load_use,
    input  logic [STAGES-1:0] except_req,
    input  logic              eret,
    output logic              pc_stall,
    output logic [1:0]        pc_select,
    output logic [STAGES-1:0] stage_stall,
    output logic [STAGES-1:0] stage_flush,
    output logic              exception,
    output logic [2:0]        except_stage,
    output logic              imem_timeout,
    output logic              dmem_timeout,
    output logic              retire,
    output logic [31:0]       retired_count
);

    localparam logic [7:0] TIMEOUT_VAL = 8'(MEM_TIMEOUT);
    localparam logic [2:0] BUBBLE_LAST = 3'(ERET_BUBBLES - 1);

    typedef enum logic {RUN, ERET_WAIT} state_t;

    state_t            state, state_next;
    logic [2:0]        bubble_cnt, bubble_next;
    logic [7:0]        imem_wait_cnt, dmem_wait_cnt;
    logic              imem_waiting, dmem_waiting;
    logic              imem_hit, dmem_hit;
    logic [STAGES-1:0] trap_vec;
    logic [2:0]        trap_idx;
    logic              trap_any;

    assign imem_waiting = imem_en & ~imem_ready;
    assign dmem_waiting = dmem_en & ~dmem_ready;

    // A zero timeout disables the trap; dmem takes precedence when both expire together.
    assign imem_hit     = rst && (MEM_TIMEOUT != 0) && (imem_wait_cnt == TIMEOUT_VAL);
    assign dmem_hit     = rst && (MEM_TIMEOUT != 0) && (dmem_wait_cnt == TIMEOUT_VAL);
    assign dmem_timeout = dmem_hit;
    assign imem_timeout = imem_hit & ~dmem_hit;

    always_comb begin
        trap_vec = except_req;
        if (imem_timeout) trap_vec[0] = 1'b1;
        if (dmem_timeout) trap_vec[STAGES-1] = 1'b1;
        trap_idx = '0;
        for (int i = 0; i < STAGES; i++) begin
            if (trap_vec[i]) trap_idx = 3'(i);
        end
    end

    assign trap_any = |trap_vec;

    always_comb begin
        state_next   = state;
        bubble_next  = bubble_cnt;
        pc_stall     = 1'b0;
        pc_select    = 2'd0;
        stage_stall  = '0;
        stage_flush  = '0;
        exception    = 1'b0;
        except_stage = '0;
        if (!rst) begin
            pc_stall    = 1'b1;
            stage_stall = '1;
        end else if (trap_any) begin
            exception    = 1'b1;
            pc_select    = 2'd2;
            except_stage = trap_idx;
            for (int i = 0; i < STAGES; i++) begin
                stage_flush[i] = (3'(i) <= trap_idx);
            end
            state_next  = RUN;
            bubble_next = '0;
        end else if (state == ERET_WAIT) begin
            pc_stall    = 1'b1;
            stage_stall = '1;
            if (bubble_cnt == BUBBLE_LAST) begin
                state_next  = RUN;
                bubble_next = '0;
            end else begin
                bubble_next = bubble_cnt + 3'd1;
            end
        end else if (eret) begin
            // The fetch side is being redirected anyway, so only a dmem wait holds it.
            pc_select   = 2'd3;
            stage_flush = '1;
            if (dmem_waiting) begin
                pc_stall    = 1'b1;
                stage_stall = '1;
            end
            state_next  = ERET_WAIT;
            bubble_next = '0;
        end else if (branch_taken) begin
            pc_select      = 2'd1;
            stage_flush[0] = 1'b1;
        end else if (imem_waiting || dmem_waiting) begin
            pc_stall    = 1'b1;
            stage_stall = '1;
        end else if (load_use) begin
            pc_stall         = 1'b1;
            stage_stall[1:0] = 2'b11;
            stage_flush[2]   = 1'b1;
        end
    end

    assign retire = ~stage_stall[STAGES-1] & ~stage_flush[STAGES-1] & ~exception;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= RUN;
            bubble_cnt    <= '0;
            imem_wait_cnt <= '0;
            dmem_wait_cnt <= '0;
            retired_count <= '0;
        end else begin
            state      <= state_next;
            bubble_cnt <= bubble_next;
            if (exception || !imem_waiting) imem_wait_cnt <= '0;
            else                            imem_wait_cnt <= imem_wait_cnt + 8'd1;
            if (exception || !dmem_waiting) dmem_wait_cnt <= '0;
            else                            dmem_wait_cnt <= dmem_wait_cnt + 8'd1;
            if (retire) retired_count <= retired_count + 32'd1;
        end
    end

endmodule

// File: doc/elbeth_pipeline_controller.md
ELBETH_PIPELINE_CONTROLLER -- requirements
Module: elbeth_pipeline_controller

Interface
REQ-001 SHALL have parameter STAGES, default 3, meaning pipeline depth; legal range 3..8; stage 0 = fetch, stage STAGES-1 = oldest (memory/writeback).
REQ-002 SHALL have parameter MEM_TIMEOUT, default 255, meaning consecutive wait cycles before a bus-timeout trap; 0 disables the timeout; counter width is 8 bits.
REQ-003 SHALL have parameter ERET_BUBBLES, default 1, meaning stall cycles after an eret redirect; legal range 1..7.
REQ-004 SHALL have ports, one per line:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- imem_en, imem_ready  in  1 each  instruction memory request and completion.
- dmem_en, dmem_ready  in  1 each  data memory request and completion, oldest stage.
- branch_taken  in  1  branch resolved taken in stage 1.
- load_use  in  1  hazard unit load-use interlock request.
- except_req  in  STAGES  per-stage exception request.
- eret  in  1  eret in oldest stage.
- pc_stall  out  1  hold the PC.
- pc_select  out  2  0 pc+4, 1 branch, 2 trap vector, 3 epc.
- stage_stall  out  STAGES  per-stage hold.
- stage_flush  out  STAGES  per-stage bubble insert.
- exception  out  1  trap taken this cycle.
- except_stage  out  3  index of the trapping stage.
- imem_timeout, dmem_timeout  out  1 each  single-cycle timeout pulses.
- retire  out  1  oldest-stage instruction retires.
- retired_count  out  32  retired instruction counter.

Function
REQ-005 SHALL implement an FSM with states RUN and ERET_WAIT.
REQ-006 SHALL decode event priority each cycle, highest first: exception, eret, branch_taken, memory stall, load_use.
REQ-007 SHALL define an exception as any except_req bit set or a timeout pulse. The trapping stage is the highest asserted index; an imem timeout counts as stage 0 and a dmem timeout as stage STAGES-1.
REQ-008 SHALL, on an exception:
- drive exception=1, pc_select=2, except_stage=trapping index;
- set stage_flush bits 0..trapping index;
- clear all stage_stall bits;
- hold pc_stall=0;
- apply combinationally in the same cycle.
REQ-009 SHALL, on eret in RUN with no exception:
- drive pc_select=3 and flush all stages that cycle;
- then enter ERET_WAIT for exactly ERET_BUBBLES cycles, with pc_stall=1 and all stage_stall=1;
- then return to RUN.
REQ-010 SHALL, in ERET_WAIT:
- ignore eret and branch_taken;
- still honour exceptions, which force a return to RUN, clear the bubble counter, and drive REQ-008 outputs.
REQ-011 SHALL, on branch_taken with no higher event, drive pc_select=1 and stage_flush[0]=1, with no stall.
REQ-012 SHALL treat a memory stall as (imem_en & ~imem_ready) | (dmem_en & ~dmem_ready). With no higher event it drives pc_stall=1, all stage_stall=1 and no flush.
REQ-013 SHALL, on load_use with no higher event, drive pc_stall=1, stage_stall[1:0]=2'b11, stage_flush[2]=1, and leave other stages free.
REQ-014 SHALL ignore an imem stall during the eret redirect cycle; a dmem stall still stalls.
REQ-015 SHALL keep separate 8-bit wait counters for imem and dmem, with this behaviour:
- a counter increments each cycle its port waits and clears when the port is not waiting or on any exception;
- when the counter equals MEM_TIMEOUT (nonzero), the matching timeout output pulses for one cycle and the counter clears;
- if both ports time out in the same cycle, dmem wins and the imem counter also clears.
REQ-016 SHALL compute retire = ~stage_stall[STAGES-1] & ~stage_flush[STAGES-1] & ~exception.
REQ-017 SHALL increment retired_count by 1 on each retire and wrap from 0xFFFFFFFF to 0.
REQ-018 SHALL drive pc_select=0 and zero flush/exception outputs when no event is active.

Reset
REQ-019 SHALL, while rst=0 at a clock edge, clear the FSM to RUN, clear the bubble counter, both wait counters and retired_count.
REQ-020 SHALL, while rst=0, drive stage_stall all ones, pc_stall=1, stage_flush=0, exception=0, pc_select=0, retire=0 and both timeouts 0.
REQ-021 SHALL abort an eret sequence or a pending timeout count when reset is asserted mid-operation, with no pulse emitted afterwards.

Verification
REQ-022 SHALL check: STAGES=4, except_req=4'b0100 together with branch_taken -> exception=1, except_stage=2, stage_flush=4'b0111, pc_select=2, retire=0.
REQ-023 SHALL check: ERET_BUBBLES=3, single eret pulse -> pc_select=3 and flush=all for 1 cycle, then pc_stall=1 for exactly 3 cycles, then RUN.
REQ-024 SHALL check: MEM_TIMEOUT=4, dmem_en=1 and dmem_ready=0 held -> dmem_timeout pulses on the 5th wait cycle, exception with except_stage=STAGES-1, and the counter restarts at 0.
REQ-025 SHALL check: load_use=1 alone, STAGES=3 -> stage_stall=3'b011, stage_flush=3'b100, pc_stall=1, retire=0.
REQ-026 SHALL check: preload 0xFFFFFFFF by retiring instructions in an unstalled stream -> the next retire wraps retired_count to 0.
REQ-027 SHALL check: rst=0 asserted during ERET_WAIT -> the next cycle shows state RUN, counters 0, and stage_stall all ones while reset is held.
